// File: rtl/dcim_macro_seq_pkg.sv
// Shared types for the DCIM macro sequencer: command opcodes, FSM states and timeout sizing.
package dcim_pkg;

  typedef enum logic {
    OP_WRITE   = 1'b0,
    OP_COMPUTE = 1'b1
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_PULSE,
    ST_WR_GAP,
    ST_CP_SETUP,
    ST_CP_START,
    ST_CP_WAIT
  } state_t;

  localparam int unsigned DCIM_TIMEOUT_CYC_DEF = 1024;

  // Counter width able to hold the full timeout limit.
  function automatic int unsigned dcim_timeout_w(input int unsigned cyc);
    return $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/dcim_macro_seq_if.sv
// Command and result handshake bundle between a host (master) and the DCIM sequencer (slave).
interface dcim_macro_seq_if #(
  parameter int unsigned N_ROWS = 8,
  parameter int unsigned D_W    = 24,
  parameter int unsigned XIN_W  = 192,
  parameter int unsigned ACC_W  = 55
) ();
  import dcim_pkg::*;

  localparam int unsigned ROW_W = $clog2(N_ROWS);

  logic             cmd_valid;
  logic             cmd_ready;
  op_t              cmd_op;
  logic [ROW_W-1:0] cmd_row;
  logic [D_W-1:0]   cmd_data;
  logic [XIN_W-1:0] cmd_xin;
  logic             cmd_inwidth;
  logic             cmd_wwidth;
  logic             cmd_acc;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_data, cmd_xin, cmd_inwidth, cmd_wwidth, cmd_acc,
    output res_ready,
    input  cmd_ready, res_valid, res_data, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_data, cmd_xin, cmd_inwidth, cmd_wwidth, cmd_acc,
    input  res_ready,
    output cmd_ready, res_valid, res_data, res_err
  );

endinterface

// File: rtl/dcim_macro_seq_timeout_ctr.sv
// Compute-wait watchdog: cleared by load, counts while enabled, flags the last allowed cycle.
module dcim_timeout_ctr #(
  parameter int unsigned LIMIT = 1024,
  parameter int unsigned W     = 11
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [W-1:0] count_q, count_d;

  assign expire = en && (count_q == W'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en && !expire) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dcim_macro_seq.sv
// Command-driven sequencer for the DCIM macro: weight writes, compute start/wait, optional accumulation.
// Optional DCIM_TIMEOUT_EN: abort a compute wait after TIMEOUT_CYC cycles and report res_err.
module dcim_macro_seq
  import dcim_pkg::*;
#(
  parameter int unsigned N_ROWS      = 8,
  parameter int unsigned D_W         = 24,
  parameter int unsigned XIN_W       = 192,
  parameter int unsigned NOUT_W      = 51,
  parameter int unsigned ACC_W       = 55,
  parameter int unsigned TIMEOUT_CYC = DCIM_TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  dcim_macro_seq_if.slave   bus,
  output logic [N_ROWS-1:0] m_WA,
  output logic [D_W-1:0]    m_D,
  output logic              m_acm_en,
  output logic              m_cima,
  output logic              m_start,
  output logic [XIN_W-1:0]  m_xin,
  output logic              m_inwidth,
  output logic              m_wwidth,
  input  logic [NOUT_W-1:0] m_nout,
  input  logic              m_st,
  output logic              busy
);

  localparam logic [N_ROWS-1:0] WA_ONE = N_ROWS'(1);

  state_t             state_q, state_d;
  logic [N_ROWS-1:0]  wa_q, wa_d;
  logic [D_W-1:0]     d_q, d_d;
  logic               acm_en_q, acm_en_d;
  logic               cima_q, cima_d;
  logic               start_q, start_d;
  logic [XIN_W-1:0]   xin_q, xin_d;
  logic               inw_q, inw_d;
  logic               ww_q, ww_d;
  logic               acc_mode_q, acc_mode_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               res_valid_q, res_valid_d;
  logic [ACC_W-1:0]   res_data_q, res_data_d;
  logic               st_q, st_d;
  logic               cmd_ready;
  logic               cmd_fire;
  logic               st_rise;

`ifdef DCIM_TIMEOUT_EN
  localparam int unsigned DCIM_TIMEOUT_W = dcim_timeout_w(TIMEOUT_CYC);
  logic res_err_q, res_err_d;
  logic tmo_expire;

  dcim_timeout_ctr #(
    .LIMIT (TIMEOUT_CYC),
    .W     (DCIM_TIMEOUT_W)
  ) u_timeout_ctr (
    .clk    (clk),
    .rstn   (rstn),
    .load   (state_q == ST_CP_START),
    .en     (state_q == ST_CP_WAIT),
    .expire (tmo_expire)
  );

  assign bus.res_err = res_err_q;
`else
  assign bus.res_err = 1'b0;
`endif

  assign cmd_ready     = (state_q == ST_IDLE) && !res_valid_q;
  assign cmd_fire      = bus.cmd_valid && cmd_ready;
  // Only a fresh low-to-high transition ends a job; a level left high from the previous job does not.
  assign st_rise       = m_st && !st_q;

  assign bus.cmd_ready = cmd_ready;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign m_WA          = wa_q;
  assign m_D           = d_q;
  assign m_acm_en      = acm_en_q;
  assign m_cima        = cima_q;
  assign m_start       = start_q;
  assign m_xin         = xin_q;
  assign m_inwidth     = inw_q;
  assign m_wwidth      = ww_q;
  assign busy          = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    wa_d        = wa_q;
    d_d         = d_q;
    acm_en_d    = acm_en_q;
    cima_d      = cima_q;
    start_d     = start_q;
    xin_d       = xin_q;
    inw_d       = inw_q;
    ww_d        = ww_q;
    acc_mode_d  = acc_mode_q;
    acc_d       = acc_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    st_d        = m_st;
`ifdef DCIM_TIMEOUT_EN
    res_err_d   = res_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
        end
        if (cmd_fire) begin
          acm_en_d = 1'b1;
          if (bus.cmd_op == OP_WRITE) begin
            // Out-of-range rows shift the one bit off the end, leaving WA all zero.
            wa_d    = WA_ONE << bus.cmd_row;
            d_d     = bus.cmd_data;
            cima_d  = 1'b0;
            state_d = ST_WR_PULSE;
          end else begin
            xin_d      = bus.cmd_xin;
            inw_d      = bus.cmd_inwidth;
            ww_d       = bus.cmd_wwidth;
            acc_mode_d = bus.cmd_acc;
            cima_d     = 1'b1;
            state_d    = ST_CP_SETUP;
          end
        end
      end
      ST_WR_PULSE: begin
        wa_d    = '0;
        state_d = ST_WR_GAP;
      end
      ST_WR_GAP: begin
        acm_en_d = 1'b0;
        state_d  = ST_IDLE;
      end
      ST_CP_SETUP: begin
        start_d = 1'b1;
        state_d = ST_CP_START;
      end
      ST_CP_START: begin
        start_d = 1'b0;
        state_d = ST_CP_WAIT;
      end
      ST_CP_WAIT: begin
        if (st_rise) begin
          acc_d       = acc_mode_q ? (acc_q + ACC_W'(m_nout)) : ACC_W'(m_nout);
          res_data_d  = acc_d;
          res_valid_d = 1'b1;
          cima_d      = 1'b0;
          acm_en_d    = 1'b0;
          state_d     = ST_IDLE;
`ifdef DCIM_TIMEOUT_EN
          res_err_d   = 1'b0;
        end else if (tmo_expire) begin
          res_data_d  = '0;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          cima_d      = 1'b0;
          acm_en_d    = 1'b0;
          state_d     = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      wa_q        <= '0;
      d_q         <= '0;
      acm_en_q    <= 1'b0;
      cima_q      <= 1'b0;
      start_q     <= 1'b0;
      xin_q       <= '0;
      inw_q       <= 1'b0;
      ww_q        <= 1'b0;
      acc_mode_q  <= 1'b0;
      acc_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      st_q        <= 1'b0;
`ifdef DCIM_TIMEOUT_EN
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wa_q        <= wa_d;
      d_q         <= d_d;
      acm_en_q    <= acm_en_d;
      cima_q      <= cima_d;
      start_q     <= start_d;
      xin_q       <= xin_d;
      inw_q       <= inw_d;
      ww_q        <= ww_d;
      acc_mode_q  <= acc_mode_d;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      st_q        <= st_d;
`ifdef DCIM_TIMEOUT_EN
      res_err_q   <= res_err_d;
`endif
    end
  end

endmodule
